// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the IF stage (read-only
// fetch) and the MEM stage (lw/sw). One access at a time, MEM has priority,
// and operands are latched at grant.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   if_req/if_addr          fetch request (level, held until if_ack)
//   if_ack/if_rdata         one-cycle ack pulse, registered fetch data
//   mem_req/mem_we/...      data request (level, held until mem_ack)
//   mem_ack/mem_rdata       one-cycle ack pulse, registered load data
//   ram_en/ram_we/...       RAM strobe (one cycle per grant) and latched operands
//   ram_rdata               RAM read data, valid MEM_LATENCY cycles after ram_en
//   stall                   combinational: any request not yet acked
//   busy                    high in every state but IDLE
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               owner_mem, owner_mem_n;
  logic               owner_req;
  logic               ram_en_n, ram_we_n, if_ack_n, mem_ack_n, busy_n;
  logic [ADDR_W-1:0]  ram_addr_n;
  logic [DATA_W-1:0]  ram_wdata_n, if_rdata_n, mem_rdata_n;

  // Stall is the only unregistered output: it must drop in the ack cycle.
  assign stall = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  // Request line of whoever currently owns the RAM; low means flushed.
  assign owner_req = owner_mem ? mem_req : if_req;

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_mem <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      owner_mem <= owner_mem_n;
      ram_en    <= ram_en_n;
      ram_we    <= ram_we_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      if_ack    <= if_ack_n;
      mem_ack   <= mem_ack_n;
      if_rdata  <= if_rdata_n;
      mem_rdata <= mem_rdata_n;
      busy      <= busy_n;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    owner_mem_n = owner_mem;
    ram_en_n    = 1'b0;
    ram_we_n    = ram_we;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    if_ack_n    = 1'b0;
    mem_ack_n   = 1'b0;
    if_rdata_n  = if_rdata;
    mem_rdata_n = mem_rdata;

    case (state)
      IDLE: begin
        // MEM first: it belongs to the older instruction.
        if (mem_req) begin
          owner_mem_n = 1'b1;
          ram_addr_n  = mem_addr;
          ram_we_n    = mem_we;
          ram_wdata_n = mem_wdata;
          ram_en_n    = 1'b1;
          state_n     = ISSUE;
        end else if (if_req) begin
          owner_mem_n = 1'b0;
          ram_addr_n  = if_addr;
          ram_we_n    = 1'b0;
          ram_en_n    = 1'b1;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = CNT_W'(MEM_LATENCY);
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        // Last wait cycle: ram_rdata is valid now. A dropped request
        // (flush) still completes the RAM access but gets no ack or data.
        if (cnt == CNT_W'(1)) begin
          state_n = ACK;
          if (owner_req) begin
            if (owner_mem) begin
              mem_ack_n = 1'b1;
              if (!ram_we) begin
                mem_rdata_n = ram_rdata;
              end
            end else begin
              if_ack_n   = 1'b1;
              if_rdata_n = ram_rdata;
            end
          end
        end
      end
      ACK: begin
        // Requests are not sampled here so a still-high req is not re-served.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Four instances cover
// latencies 2, 3, 1 and 15; each has its own RAM model with a fixed read
// delay that shows a poison value whenever no read is due.
module tb_mem_port_arbiter;

  localparam int NI = 4;
  localparam int LAT [NI] = '{2, 3, 1, 15};

  logic        clock;
  logic        reset     [NI];
  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic        if_ack    [NI];
  logic [31:0] if_rdata  [NI];
  logic        mem_req   [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic        mem_ack   [NI];
  logic [31:0] mem_rdata [NI];
  logic        ram_en    [NI];
  logic        ram_we    [NI];
  logic [31:0] ram_addr  [NI];
  logic [31:0] ram_wdata [NI];
  logic        stall     [NI];
  logic        busy      [NI];
  logic        model_clr;

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Contents of RAM locations that have not been written.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h8C010004;
      32'h100: return 32'hDEADBEEF;
      default: return {a[15:0], 16'hA5A5};
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = LAT[g];
    logic [31:0] rd;
    logic        h_en   [16];
    logic [31:0] h_addr [16];
    logic        wr_ok  [256];
    logic [31:0] wr_data [256];

    mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_ack(mem_ack[g]), .mem_rdata(mem_rdata[g]),
      .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(rd), .stall(stall[g]), .busy(busy[g])
    );

    // h_*[k] after an edge holds the strobe of the cycle k+1 cycles back.
    always @(posedge clock) begin
      if (model_clr) begin
        for (int k = 0; k < 16; k++) begin
          h_en[k]   <= 1'b0;
          h_addr[k] <= 32'h0;
        end
        for (int k = 0; k < 256; k++) begin
          wr_ok[k]   <= 1'b0;
          wr_data[k] <= 32'h0;
        end
      end else begin
        h_en[0]   <= ram_en[g] && !ram_we[g];
        h_addr[0] <= ram_addr[g];
        for (int k = 1; k < 16; k++) begin
          h_en[k]   <= h_en[k-1];
          h_addr[k] <= h_addr[k-1];
        end
        if (ram_en[g] && ram_we[g]) begin
          wr_ok[ram_addr[g][9:2]]   <= 1'b1;
          wr_data[ram_addr[g][9:2]] <= ram_wdata[g];
        end
      end
    end

    always_comb begin
      rd = 32'hBAD0BAD0;
      if (h_en[L-1]) begin
        if (wr_ok[h_addr[L-1][9:2]]) rd = wr_data[h_addr[L-1][9:2]];
        else                         rd = rom(h_addr[L-1]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete access raised in the current cycle; req dropped on ack.
  task automatic xact(input int i, input int lat, input bit is_mem, input bit we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd);
    logic ack;
    logic [31:0] rdat;
    if (is_mem) begin
      mem_req[i] = 1'b1; mem_we[i] = we; mem_addr[i] = addr; mem_wdata[i] = wdata;
    end else begin
      if_req[i] = 1'b1; if_addr[i] = addr;
    end
    #1;
    check("stall_c0", 32'(stall[i]), 32'd1);
    for (int c = 1; c <= lat + 2; c++) begin
      tick();
      ack  = is_mem ? mem_ack[i] : if_ack[i];
      rdat = is_mem ? mem_rdata[i] : if_rdata[i];
      check("ram_en", 32'(ram_en[i]), 32'(c == 1));
      check("busy", 32'(busy[i]), 32'd1);
      check("ack", 32'(ack), 32'(c == lat + 2));
      check("stall", 32'(stall[i]), 32'(c < lat + 2));
      if (c == 1) begin
        check("ram_addr", ram_addr[i], addr);
        check("ram_we", 32'(ram_we[i]), 32'(we));
        if (we) check("ram_wdata", ram_wdata[i], wdata);
        // Operand changes after grant must not reach the RAM port.
        if_addr[i] = ~addr; mem_addr[i] = ~addr; mem_wdata[i] = ~wdata;
      end
      if (c == 2) check("ram_addr_held", ram_addr[i], addr);
      if (c == lat + 2) begin
        check("rdata", rdat, exp_rd);
        if (is_mem) mem_req[i] = 1'b0; else if_req[i] = 1'b0;
      end
    end
    tick();
    check("busy_idle", 32'(busy[i]), 32'd0);
    check("ack_once", 32'(is_mem ? mem_ack[i] : if_ack[i]), 32'd0);
  endtask

  task automatic check_zero(input string tag, input int i);
    check({tag, "_ram_en"}, 32'(ram_en[i]), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we[i]), 32'd0);
    check({tag, "_ram_addr"}, ram_addr[i], 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata[i], 32'd0);
    check({tag, "_if_ack"}, 32'(if_ack[i]), 32'd0);
    check({tag, "_mem_ack"}, 32'(mem_ack[i]), 32'd0);
    check({tag, "_if_rdata"}, if_rdata[i], 32'd0);
    check({tag, "_mem_rdata"}, mem_rdata[i], 32'd0);
    check({tag, "_busy"}, 32'(busy[i]), 32'd0);
  endtask

  initial begin
    model_clr = 1'b1;
    for (int i = 0; i < NI; i++) begin
      reset[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = 32'h0;
      mem_req[i] = 1'b0; mem_we[i] = 1'b0; mem_addr[i] = 32'h0; mem_wdata[i] = 32'h0;
    end
    tick();
    tick();
    check_zero("rst", 0);
    check_zero("rst_l15", 3);
    for (int i = 0; i < NI; i++) reset[i] = 1'b0;
    model_clr = 1'b0;
    tick();

    // Single fetch, latency 2: ack four cycles after the request.
    xact(0, 2, 1'b0, 1'b0, 32'h40, 32'h0, 32'h8C010004);

    // Simultaneous IF and MEM: MEM first, IF at the following IDLE.
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h100;
    if_req[0] = 1'b1; if_addr[0] = 32'h200;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check("t2_mem_ack", 32'(mem_ack[0]), 32'(c == 4));
      check("t2_if_ack", 32'(if_ack[0]), 32'(c == 9));
      check("t2_ram_en", 32'(ram_en[0]), 32'(c == 1 || c == 6));
      if (c == 1) check("t2_addr_mem", ram_addr[0], 32'h100);
      if (c == 4) begin
        check("t2_mem_rdata", mem_rdata[0], 32'hDEADBEEF);
        mem_req[0] = 1'b0;
      end
      if (c == 6) check("t2_addr_if", ram_addr[0], 32'h200);
      if (c == 9) begin
        check("t2_if_rdata", if_rdata[0], 32'h0200A5A5);
        if_req[0] = 1'b0;
      end
    end

    // Store then load back; the store leaves mem_rdata at its reset value.
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    xact(0, 2, 1'b1, 1'b1, 32'h10, 32'h12345678, 32'h0);
    xact(0, 2, 1'b1, 1'b0, 32'h10, 32'h0, 32'h12345678);

    // Flush during WAIT, latency 3: no ack, no data, then MEM served normally.
    if_req[1] = 1'b1; if_addr[1] = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("t4_if_ack", 32'(if_ack[1]), 32'd0);
      check("t4_if_rdata", if_rdata[1], 32'd0);
      check("t4_busy", 32'(busy[1]), 32'(c <= 5));
      if (c == 2) if_req[1] = 1'b0;
    end
    xact(1, 3, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);

    // Reset in WAIT: everything clears, the late RAM data is never captured.
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    tick();
    check("t5_ram_en", 32'(ram_en[0]), 32'd1);
    tick();
    reset[0] = 1'b1;
    if_req[0] = 1'b0;
    #1;
    check_zero("t5", 0);
    tick();
    check_zero("t5_hold", 0);
    reset[0] = 1'b0;
    xact(0, 2, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0080A5A5);

    // Latency boundaries: ack at cycle 3 and cycle 17.
    xact(2, 1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h8C010004);
    xact(3, 15, 1'b0, 1'b0, 32'h40, 32'h0, 32'h8C010004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
